seg_scan_decoder: RTL and testbench

- Receive-side decoder for the multiplexed 7-segment bus (AN, CA..CG, DP) driven by the crossroad display path.
- Samples the scanned anode/cathode lines and rebuilds the per-digit segment bytes and hex digit values.
- Publishes a complete frame once every digit has been seen stable.
- Used as an on-chip loopback monitor and as the checker end in display-path benches, for example recovering the four 2-digit lane car counters.

---
 rtl/seg_scan_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment bus (AN, CA..CG, DP).
// Rebuilds per-digit segment bytes and hex values; publishes whole frames.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   AN[DIGITS]     anode select, one-hot at the ACTIVE_LOW level
//   CA..CG, DP     segment cathodes at the ACTIVE_LOW level
//   display        recovered bytes, byte i = {DP,CG..CA} of digit i, lit=1
//   digit_value    hex nibble per digit, 0 when the glyph is unknown
//   digit_valid    per-digit flag, byte (without DP) is a known glyph
//   frame_valid    one-cycle pulse when display is updated
//   frame_changed  pulse with frame_valid when display took a new value
//   multi_an_err   sticky, set when a sample has more than one anode
module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     AN,
    input  logic                  CA,
    input  logic                  CB,
    input  logic                  CC,
    input  logic                  CD,
    input  logic                  CE,
    input  logic                  CF,
    input  logic                  CG,
    input  logic                  DP,
    output logic [DIGITS*8-1:0]   display,
    output logic [DIGITS*4-1:0]   digit_value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  frame_changed,
    output logic                  multi_an_err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [7:0] CNT_MAX = 8'hFF;
    localparam logic [DIGITS-1:0] ALL_SEEN = '1;
    localparam logic [DIGITS-1:0] AN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------
    // Input register, normalised to active-high
    // ---------------------------------------------------------------
    logic [7:0]        seg_pins;
    logic [DIGITS-1:0] an_q;
    logic [7:0]        seg_q;

    assign seg_pins = {DP, CG, CF, CE, CD, CC, CB, CA};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '0;
            seg_q <= '0;
        end else begin
            an_q  <= ACTIVE_LOW ? ~AN : AN;
            seg_q <= ACTIVE_LOW ? ~seg_pins : seg_pins;
        end
    end

    // ---------------------------------------------------------------
    // Anode classification
    // ---------------------------------------------------------------
    logic          an_any;
    logic          one_hot;
    logic          multi;
    logic [IW-1:0] idx;

    // Clearing the lowest set bit leaves zero only for a single bit.
    assign an_any  = (an_q != '0);
    assign one_hot = an_any && ((an_q & (an_q - AN_ONE)) == '0);
    assign multi   = an_any && !one_hot;

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_q[i]) begin
                idx = IW'(i);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stability counter
    // ---------------------------------------------------------------
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [IW-1:0] last_idx;
    logic [7:0]    last_seg;
    logic          same;
    logic          capture;

    // cnt == 0 means the previous sample was idle/error, so nothing
    // to continue from even if last_idx/last_seg happen to match.
    assign same = one_hot && (cnt != 8'd0) &&
                  (idx == last_idx) && (seg_q == last_seg);

    always_comb begin
        cnt_nxt = 8'd0;
        if (same) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
        end else if (one_hot) begin
            cnt_nxt = 8'd1;
        end
    end

    // Capture on the cycle the count arrives at SETTLE; a saturated
    // count sitting at SETTLE must not recapture.
    assign capture = one_hot && (cnt_nxt == SETTLE) &&
                     !(same && (cnt == SETTLE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 8'd0;
            last_idx <= '0;
            last_seg <= 8'd0;
        end else begin
            cnt      <= cnt_nxt;
            last_idx <= idx;
            last_seg <= seg_q;
        end
    end

    // ---------------------------------------------------------------
    // Shadow bytes, seen mask and frame publish
    // ---------------------------------------------------------------
    logic [DIGITS*8-1:0] shadow;
    logic [DIGITS-1:0]   seen;
    logic [DIGITS-1:0]   seen_nxt;
    logic                publish;

    assign publish = (seen == ALL_SEEN);

    // A capture in the publish cycle lands after the clear.
    always_comb begin
        seen_nxt = publish ? '0 : seen;
        if (capture) begin
            seen_nxt[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            seen   <= '0;
        end else begin
            seen <= seen_nxt;
            if (capture) begin
                shadow[{idx, 3'b000} +: 8] <= seg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display       <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            multi_an_err  <= 1'b0;
        end else begin
            frame_valid   <= publish;
            frame_changed <= publish && (shadow != display);
            multi_an_err  <= multi_an_err | multi;
            if (publish) begin
                display <= shadow;
            end
        end
    end

    // ---------------------------------------------------------------
    // Glyph decode (gfedcba, DP ignored) -> {valid, nibble}
    // ---------------------------------------------------------------
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h3F:   decode = 5'h10;
            7'h06:   decode = 5'h11;
            7'h5B:   decode = 5'h12;
            7'h4F:   decode = 5'h13;
            7'h66:   decode = 5'h14;
            7'h6D:   decode = 5'h15;
            7'h7D:   decode = 5'h16;
            7'h07:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h6F:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h7C:   decode = 5'h1B;
            7'h39:   decode = 5'h1C;
            7'h5E:   decode = 5'h1D;
            7'h79:   decode = 5'h1E;
            7'h71:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [4:0] dec;

    always_comb begin
        dec         = '0;
        digit_valid = '0;
        digit_value = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dec                    = decode(display[8*i +: 7]);
            digit_valid[i]         = dec[4];
            digit_value[4*i +: 4]  = dec[3:0];
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: scenario tasks plus randomized scans,
// checked against a pin-history reference model.
module tb_seg_scan_decoder;

    localparam int SET = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  AN = 8'hFF;
    logic        CA = 1'b1, CB = 1'b1, CC = 1'b1, CD = 1'b1;
    logic        CE = 1'b1, CF = 1'b1, CG = 1'b1, DP = 1'b1;
    logic [63:0] display;
    logic [31:0] digit_value;
    logic [7:0]  digit_valid;
    logic        frame_valid;
    logic        frame_changed;
    logic        multi_an_err;

    seg_scan_decoder #(
        .DIGITS(8), .SETTLE_CYCLES(SET), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .AN(AN),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD),
        .CE(CE), .CF(CF), .CG(CG), .DP(DP),
        .display(display), .digit_value(digit_value),
        .digit_valid(digit_valid), .frame_valid(frame_valid),
        .frame_changed(frame_changed), .multi_an_err(multi_an_err)
    );

    always #5 clk = ~clk;

    logic [7:0] glyph [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  m_shadow [8];
    logic [7:0]  m_seen;
    logic [63:0] m_disp;
    logic        m_err, m_fv, m_fc;
    logic [7:0]  qa [$];
    logic [7:0]  qs [$];

    int obs_fv, obs_fc, exp_fv, misalign;

    function automatic logic [31:0] model_val(input logic [63:0] d);
        logic [31:0] v = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 16; j++)
                if (d[8*i +: 7] == glyph[j][6:0]) v[4*i +: 4] = 4'(j);
        return v;
    endfunction

    function automatic logic [7:0] model_vld(input logic [63:0] d);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 16; j++)
                if (d[8*i +: 7] == glyph[j][6:0]) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_shadow[i] = 8'h00;
        m_seen = 8'h00; m_disp = '0; m_err = 1'b0;
        m_fv = 1'b0; m_fc = 1'b0;
        qa.delete(); qs.delete();
    endtask

    // One clock edge of the spec's rules: publish a full frame, then
    // capture the previous sample if it has been stable exactly SET
    // samples long.
    task automatic model_edge(input logic [7:0] a, input logic [7:0] s);
        logic [63:0] nd;
        logic [7:0]  la, ls;
        int run, id;
        m_fv = 1'b0; m_fc = 1'b0;
        if (m_seen == 8'hFF) begin
            for (int i = 0; i < 8; i++) nd[8*i +: 8] = m_shadow[i];
            m_fc = (nd != m_disp);
            m_disp = nd; m_fv = 1'b1; m_seen = 8'h00;
        end
        if (qa.size() > 0) begin
            la = qa[$]; ls = qs[$];
            if ($countones(la) > 1) m_err = 1'b1;
            if ($countones(la) == 1) begin
                run = 0;
                for (int i = qa.size() - 1; i >= 0; i--) begin
                    if (qa[i] == la && qs[i] == ls) run++;
                    else break;
                    if (run > SET) break;
                end
                if (run == SET) begin
                    id = 0;
                    for (int j = 0; j < 8; j++) if (la[j]) id = j;
                    m_shadow[id] = ls; m_seen[id] = 1'b1;
                end
            end
        end
        qa.push_back(a); qs.push_back(s);
        if (qa.size() > 16) begin
            void'(qa.pop_front()); void'(qs.pop_front());
        end
    endtask

    // a/s are active-high logical values; pins are active-low.
    task automatic tick(input logic [7:0] a, input logic [7:0] s);
        AN = ~a;
        {DP, CG, CF, CE, CD, CC, CB, CA} = ~s;
        @(posedge clk); #1;
        model_edge(a, s);
        if (frame_valid === 1'b1) begin
            obs_fv++;
            if (frame_changed === 1'b1) obs_fc++;
        end
        if (m_fv) exp_fv++;
        if (frame_valid !== m_fv || frame_changed !== m_fc ||
            multi_an_err !== m_err) misalign++;
    endtask

    task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
        repeat (n) tick(a, s);
    endtask

    task automatic idle(input int n);
        hold(8'h00, 8'h00, n);
    endtask

    task automatic scan(input logic [7:0] b [8], input int dwell);
        for (int d = 0; d < 8; d++) hold(8'(1 << d), b[d], dwell);
    endtask

    task automatic zero_counts();
        obs_fv = 0; obs_fc = 0; exp_fv = 0; misalign = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (display !== 64'h0 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_disp got=%h/%b want=0/0", display, frame_valid);
        end
        total++;
        if (multi_an_err !== 1'b0 || frame_changed !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b want=00", multi_an_err, frame_changed);
        end
        total++;
        if (digit_valid !== 8'h00 || digit_value !== 32'h0) begin
            bad++;
            $display("FAIL reset_dec got=%h/%h want=0/0", digit_valid, digit_value);
        end
        #3 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = glyph[i];
        zero_counts();
        repeat (3) scan(b, 8);
        idle(4);
        total++;
        if (obs_fv !== 3) begin
            bad++; $display("FAIL scan_frames got=%0d want=3", obs_fv);
        end
        total++;
        if (obs_fc !== 1) begin
            bad++; $display("FAIL scan_changed got=%0d want=1", obs_fc);
        end
        total++;
        if (digit_value !== 32'h76543210) begin
            bad++; $display("FAIL scan_value got=%h want=76543210", digit_value);
        end
        total++;
        if (digit_valid !== 8'hFF) begin
            bad++; $display("FAIL scan_valid got=%h want=ff", digit_valid);
        end
        total++;
        if (display[7:0] !== 8'h3F) begin
            bad++; $display("FAIL scan_byte0 got=%h want=3f", display[7:0]);
        end
        total++;
        if (misalign !== 0 || display !== m_disp) begin
            bad++;
            $display("FAIL scan_model got=%h/%0d want=%h/0", display, misalign, m_disp);
        end
    endtask

    task automatic test_short_dwell();
        logic f0, f1, f2;
        zero_counts();
        for (int d = 0; d < 7; d++) hold(8'(1 << d), glyph[d], 8);
        hold(8'h80, glyph[7], 3);
        idle(6);
        total++;
        if (obs_fv !== 0) begin
            bad++; $display("FAIL short3_frames got=%0d want=0", obs_fv);
        end
        hold(8'h80, glyph[7], 4);
        tick(8'h00, 8'h00); f0 = frame_valid;
        tick(8'h00, 8'h00); f1 = frame_valid;
        tick(8'h00, 8'h00); f2 = frame_valid;
        total++;
        if ({f0, f1, f2} !== 3'b010) begin
            bad++; $display("FAIL short4_timing got=%b%b%b want=010", f0, f1, f2);
        end
        total++;
        if (misalign !== 0) begin
            bad++; $display("FAIL short_model got=%0d want=0", misalign);
        end
    endtask

    task automatic test_glitch();
        zero_counts();
        for (int d = 0; d < 4; d++) hold(8'(1 << d), glyph[d], 8);
        hold(8'h10, glyph[4], 3);
        tick(8'b0000_1100, glyph[4]);
        hold(8'h10, glyph[4], 8);
        for (int d = 5; d < 8; d++) hold(8'(1 << d), glyph[d], 8);
        idle(4);
        total++;
        if (multi_an_err !== 1'b1) begin
            bad++; $display("FAIL glitch_err got=%b want=1", multi_an_err);
        end
        total++;
        if (obs_fv !== 1) begin
            bad++; $display("FAIL glitch_frames got=%0d want=1", obs_fv);
        end
        idle(5);
        total++;
        if (multi_an_err !== 1'b1 || misalign !== 0) begin
            bad++;
            $display("FAIL glitch_sticky got=%b/%0d want=1/0", multi_an_err, misalign);
        end
    endtask

    task automatic test_lanes();
        int lanes [4] = '{12, 7, 0, 99};
        logic [7:0]  b [8];
        logic [31:0] expv = '0;
        for (int l = 0; l < 4; l++) begin
            b[2*l]     = glyph[lanes[l] % 10];
            b[2*l + 1] = glyph[lanes[l] / 10];
            expv += 32'(((lanes[l] / 10) * 16 + lanes[l] % 10) << (8 * l));
        end
        zero_counts();
        scan(b, 8);
        idle(2);
        total++;
        if (obs_fv !== 1 || obs_fc !== 1) begin
            bad++; $display("FAIL lanes_first got=%0d/%0d want=1/1", obs_fv, obs_fc);
        end
        zero_counts();
        scan(b, 8);
        idle(2);
        total++;
        if (obs_fv !== 1 || obs_fc !== 0) begin
            bad++; $display("FAIL lanes_repeat got=%0d/%0d want=1/0", obs_fv, obs_fc);
        end
        total++;
        if (digit_value !== expv) begin
            bad++; $display("FAIL lanes_value got=%h want=%h", digit_value, expv);
        end
    endtask

    task automatic test_unknown();
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = glyph[i];
        b[5] = 8'h49 | 8'h80;
        zero_counts();
        scan(b, 8);
        idle(2);
        total++;
        if (display[47:40] !== 8'hC9) begin
            bad++; $display("FAIL unk_byte got=%h want=c9", display[47:40]);
        end
        total++;
        if (digit_valid !== 8'hDF) begin
            bad++; $display("FAIL unk_valid got=%h want=df", digit_valid);
        end
        total++;
        if (digit_value !== 32'h76043210) begin
            bad++; $display("FAIL unk_value got=%h want=76043210", digit_value);
        end
    endtask

    task automatic test_random();
        logic [7:0] bt;
        for (int it = 0; it < 12; it++) begin
            zero_counts();
            for (int d = 0; d < 8; d++) begin
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0) bt = 8'($urandom_range(0, 255));
                else bt = glyph[$urandom_range(0, 15)] |
                          8'($urandom_range(0, 1) << 7);
                hold(8'(1 << d), bt, $urandom_range(1, 9));
            end
            idle(3);
            total++;
            if (obs_fv !== exp_fv || misalign !== 0) begin
                bad++;
                $display("FAIL rnd_frames it=%0d got=%0d/%0d want=%0d/0",
                         it, obs_fv, misalign, exp_fv);
            end
            total++;
            if (display !== m_disp) begin
                bad++; $display("FAIL rnd_disp it=%0d got=%h want=%h", it, display, m_disp);
            end
            total++;
            if (digit_value !== model_val(m_disp) ||
                digit_valid !== model_vld(m_disp)) begin
                bad++;
                $display("FAIL rnd_dec it=%0d got=%h/%h want=%h/%h", it,
                         digit_value, digit_valid,
                         model_val(m_disp), model_vld(m_disp));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = glyph[i + 8];
        for (int d = 0; d < 4; d++) hold(8'(1 << d), b[d], 8);
        #3 rst = 1'b0;
        #1;
        total++;
        if (display !== 64'h0 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_disp got=%h/%b want=0/0", display, frame_valid);
        end
        total++;
        if (multi_an_err !== 1'b0 || digit_valid !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_flags got=%b/%h want=0/00", multi_an_err, digit_valid);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        zero_counts();
        for (int d = 4; d < 8; d++) hold(8'(1 << d), b[d], 8);
        idle(6);
        total++;
        if (obs_fv !== 0) begin
            bad++; $display("FAIL rstmid_partial got=%0d want=0", obs_fv);
        end
        scan(b, 8);
        idle(3);
        total++;
        if (obs_fv !== 1 || digit_value !== 32'hFEDCBA98) begin
            bad++;
            $display("FAIL rstmid_full got=%0d/%h want=1/fedcba98", obs_fv, digit_value);
        end
        total++;
        if (misalign !== 0 || digit_valid !== 8'hFF) begin
            bad++;
            $display("FAIL rstmid_model got=%0d/%h want=0/ff", misalign, digit_valid);
        end
    endtask

    initial begin
        model_reset();
        zero_counts();
        test_reset();
        test_scan();
        test_short_dwell();
        test_glitch();
        test_lanes();
        test_unknown();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
